// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result port, LSU return port, register-file write port and status.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface wb_arbiter_if #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned LSU_FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(LSU_FIFO_DEPTH) + 1;

    logic            alu_valid_i;
    logic            alu_ready_o;
    logic [4:0]      alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [4:0]      lsu_rd_i;
    logic [XLEN-1:0] lsu_data_i;
    logic [4:0]      w_addr_o;
    logic [XLEN-1:0] w_value_o;
    logic [CntW-1:0] fifo_count_o;
    logic            busy_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output alu_ready_o, lsu_ready_o,
        output w_addr_o, w_value_o, fifo_count_o, busy_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  alu_ready_o, lsu_ready_o,
        input  w_addr_o, w_value_o, fifo_count_o, busy_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win over the buffered LSU return FIFO; one registered write/cycle.
// Define WB_STARVE_GUARD_EN to force a FIFO drain after STARVE_LIMIT bypassed cycles.
module wb_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned LSU_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input logic         clk,
    input logic         reset_n,
    wb_arbiter_if.slave wb_io
);
    localparam int unsigned PtrW = $clog2(LSU_FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    if ((LSU_FIFO_DEPTH < 2) || ((LSU_FIFO_DEPTH & (LSU_FIFO_DEPTH - 1)) != 0) ||
        (STARVE_LIMIT < 1)) begin : g_param_check
        $error("wb_arbiter: LSU_FIFO_DEPTH must be a power of 2 >= 2, STARVE_LIMIT >= 1");
    end

    entry_t          mem_q [LSU_FIFO_DEPTH];
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    cnt_t            count_q, count_d;
    logic [4:0]      w_addr_q, w_addr_d;
    logic [XLEN-1:0] w_value_q, w_value_d;

    logic   fifo_empty;
    logic   lsu_ready;
    logic   alu_ready;
    logic   alu_win;
    logic   push;
    logic   pop;
    entry_t head;

    assign fifo_empty = (count_q == '0);
    // Ready comes from the registered count only, so a full FIFO never takes a push.
    assign lsu_ready  = (count_q < cnt_t'(LSU_FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign push       = wb_io.lsu_valid_i && lsu_ready;
    assign alu_win    = wb_io.alu_valid_i && alu_ready;
    assign pop        = !alu_win && !fifo_empty;

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_q, starve_d;

    // At the limit the ALU is refused, which makes pop true and clears the counter.
    assign alu_ready = (starve_q != StarveW'(STARVE_LIMIT));

    always_comb begin
        starve_d = '0;
        if (!fifo_empty && !pop) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign alu_ready = 1'b1;
`endif

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        w_addr_d  = '0;
        w_value_d = '0;

        if (alu_win) begin
            w_addr_d  = wb_io.alu_rd_i;
            w_value_d = wb_io.alu_data_i;
        end else if (pop) begin
            w_addr_d  = head.rd;
            w_value_d = head.data;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            w_addr_q  <= '0;
            w_value_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            w_addr_q  <= w_addr_d;
            w_value_q <= w_value_d;
        end
    end

    // Storage needs no reset: entries are only visible through the reset pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_t'{rd: wb_io.lsu_rd_i, data: wb_io.lsu_data_i};
        end
    end

    assign wb_io.alu_ready_o  = alu_ready;
    assign wb_io.lsu_ready_o  = lsu_ready;
    assign wb_io.w_addr_o     = w_addr_q;
    assign wb_io.w_value_o    = w_value_q;
    assign wb_io.fifo_count_o = count_q;
    assign wb_io.busy_o       = !fifo_empty;
endmodule
